// File: rtl/pairing_result_serializer.sv
// pairing_result_serializer
// Captures the wide pairing result on the rising edge of the core's done flag
// and streams it out LSW-first as WORD_W-bit words under valid/ready.
// The captured copy is held privately, so the core may restart right after capture.
//
// state | meaning
// IDLE  | no result held for the host; waiting for a done rise
// SEND  | presenting word cnt_q of the captured result on tx_data
module pairing_result_serializer #(
  parameter int RES_W  = 1164,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_done,
  input  logic [RES_W-1:0]  core_out,
  input  logic              flush,
  input  logic              tx_ready,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              busy,
  output logic              sent,
  output logic              overrun
);

  localparam int NWORDS = (RES_W + WORD_W - 1) / WORD_W;
  localparam int SR_W   = NWORDS * WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             sent_q, sent_d;
  logic             overrun_q, overrun_d;

  logic rise;
  logic hs;
  logic is_last;

  assign rise    = core_done & ~done_q;
  assign hs      = (state_q == S_SEND) & tx_ready;
  assign is_last = (cnt_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: captured result, word index, edge detector, flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      sent_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      done_q    <= core_done;
      sent_q    <= sent_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and datapath update; flush outranks both capture and handshake.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    sent_d    = 1'b0;
    overrun_d = overrun_q;
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            sr_d    = SR_W'(core_out);
            cnt_d   = '0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (hs && is_last) begin
            sent_d = 1'b1;
            cnt_d  = '0;
            // A rise landing on the final handshake is chained straight in.
            if (rise) sr_d = SR_W'(core_out);
            else      state_d = S_IDLE;
          end else begin
            if (hs) begin
              sr_d  = sr_q >> WORD_W;
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (rise) overrun_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded only from registers, so tx_ready never reaches tx_valid.
  always_comb begin
    tx_valid = (state_q == S_SEND);
    busy     = (state_q == S_SEND);
    tx_data  = (state_q == S_SEND) ? sr_q[WORD_W-1:0] : '0;
    tx_last  = (state_q == S_SEND) & is_last;
    sent     = sent_q;
    overrun  = overrun_q;
  end

endmodule

// File: tb/tb_pairing_result_serializer.sv
// Self-checking bench for pairing_result_serializer.
// The reference holds the pending result as a queue of words: a handshake
// pops the front, the last word is the one left alone in the queue.
module tb_pairing_result_serializer;

  localparam int RES_W  = 1164;
  localparam int WORD_W = 32;
  localparam int NWORDS = 37;
  localparam int SR_W   = NWORDS * WORD_W;

  logic              clk;
  logic              reset;
  logic              core_done;
  logic [RES_W-1:0]  core_out;
  logic              flush;
  logic              tx_ready;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              busy;
  logic              sent;
  logic              overrun;

  pairing_result_serializer #(.RES_W(RES_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .core_done (core_done),
    .core_out  (core_out),
    .flush     (flush),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .busy      (busy),
    .sent      (sent),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // requested inputs for the next edge
  logic             r_done, r_flush, r_ready;
  logic [RES_W-1:0] r_out;

  // reference model
  logic [WORD_W-1:0] m_q[$];
  logic              m_prev_done;
  logic              m_sent;
  logic              m_ovr;
  logic [RES_W-1:0]  cur_res;
  logic [SR_W-1:0]   rx;
  int                rx_idx;
  logic [WORD_W-1:0] obs_data;

  logic [RES_W-1:0] res_a, res_b, res_c, res_d, res_e;

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] rand_res();
    logic [RES_W-1:0] v;
    v = '0;
    for (int k = 0; k < NWORDS; k++) v = (v << 32) | RES_W'($urandom);
    return v;
  endfunction

  task automatic capture(input logic [RES_W-1:0] res);
    logic [SR_W-1:0] pad;
    pad = SR_W'(res);
    cur_res = res;
    m_q.delete();
    for (int k = 0; k < NWORDS; k++) m_q.push_back(pad[k*WORD_W +: WORD_W]);
    rx = '0;
    rx_idx = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev_done = 1'b0;
    m_sent = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    obs_data = tx_data;
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() > 0});
    chk("busy",     {31'b0, busy},     {31'b0, m_q.size() > 0});
    chk("tx_last",  {31'b0, tx_last},  {31'b0, m_q.size() == 1});
    chk("sent",     {31'b0, sent},     {31'b0, m_sent});
    chk("overrun",  {31'b0, overrun},  {31'b0, m_ovr});
    if (m_q.size() > 0) chk("tx_data", tx_data, m_q[0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_data"},  tx_data, '0);
    chk({tag, "_tx_valid"}, {31'b0, tx_valid}, '0);
    chk({tag, "_tx_last"},  {31'b0, tx_last}, '0);
    chk({tag, "_busy"},     {31'b0, busy}, '0);
    chk({tag, "_sent"},     {31'b0, sent}, '0);
    chk({tag, "_overrun"},  {31'b0, overrun}, '0);
  endtask

  // Apply requested inputs and advance the model to the state after the next edge.
  task automatic drive_and_update();
    logic rise, final_hs;
    core_done = r_done;
    core_out  = r_out;
    flush     = r_flush;
    tx_ready  = r_ready;
    rise = r_done && !m_prev_done;
    m_prev_done = r_done;
    m_sent = 1'b0;
    if (r_flush) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else if (m_q.size() == 0) begin
      if (rise) capture(r_out);
    end else begin
      final_hs = r_ready && (m_q.size() == 1);
      if (r_ready) begin
        rx[rx_idx*WORD_W +: WORD_W] = obs_data;
        rx_idx++;
        void'(m_q.pop_front());
      end
      if (final_hs) begin
        m_sent = 1'b1;
        n_assert++;
        assert (rx === SR_W'(cur_res)) else begin
          n_fail++;
          $error("FAIL reassembly observed=%0h expected=%0h", rx[63:0], cur_res[63:0]);
        end
        if (rise) capture(r_out);
      end else if (rise) begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    drive_and_update();
  endtask

  task automatic run_stream(input bit bp);
    for (int i = 0; i < 400; i++) begin
      if (m_q.size() == 0) break;
      r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    r_ready = 1'b1;
    if (m_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL stream_timeout observed=%0d expected=0", m_q.size());
    end
  endtask

  initial begin
    bit fired;
    for (int i = 0; i < RES_W; i++) res_a[i] = (i % 3 == 0);
    res_b = rand_res();
    res_c = rand_res();
    res_d = rand_res();
    res_e = rand_res();

    // reset
    reset = 1'b0;
    r_done = 1'b0; r_flush = 1'b0; r_ready = 1'b1; r_out = '0;
    core_done = 1'b0; core_out = '0; flush = 1'b0; tx_ready = 1'b1;
    model_reset();
    obs_data = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    drive_and_update();
    tick();

    // basic stream
    r_done = 1'b1; r_out = res_a;
    tick();
    @(posedge clk); #1;
    chk("word0", tx_data, 32'h49249249);
    run_stream(1'b0);
    repeat (3) tick();

    // backpressure
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_b; tick();
    run_stream(1'b1);
    repeat (2) tick();

    // back-to-back: next rise lands exactly on the last-word handshake
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_c; tick();
    fired = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_q.size() == 0) break;
      if (!fired && m_q.size() == 1) begin
        r_done = 1'b1; r_out = res_d; fired = 1'b1;
      end else if (!fired) begin
        r_done = 1'b0;
      end
      tick();
    end
    repeat (2) tick();

    // overrun: second rise mid-stream is dropped
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_a; tick();
    for (int i = 0; i < 100; i++) begin
      if (m_q.size() == 0) break;
      if (m_q.size() == NWORDS - 10) r_done = 1'b0;
      else if (m_q.size() == NWORDS - 11) begin r_done = 1'b1; r_out = res_e; end
      tick();
    end
    repeat (5) tick();

    // flush with a simultaneous rise at word 5
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_b; tick();
    for (int i = 0; i < 100; i++) begin
      if (m_q.size() == NWORDS - 4) r_done = 1'b0;
      if (m_q.size() == NWORDS - 5) begin
        r_done = 1'b1; r_flush = 1'b1; tick();
        break;
      end
      tick();
    end
    r_flush = 1'b0;
    repeat (2) tick();
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_d; tick();
    run_stream(1'b0);
    tick();

    // asynchronous reset at word 20
    r_done = 1'b0; tick();
    r_done = 1'b1; r_out = res_e; tick();
    for (int i = 0; i < 100; i++) begin
      if (m_q.size() == NWORDS - 20) break;
      tick();
    end
    #2 reset = 1'b0;
    #1 check_zero("async");
    model_reset();
    @(negedge clk);
    check_zero("inreset");
    reset = 1'b1;
    drive_and_update();
    run_stream(1'b1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pairing_result_serializer.md
Name: pairing_result_serializer

Overview:
- Downstream of the Tate pairing top level: captures the wide F3^6m result when the pairing core's done flag rises.
- Streams the result to the host bus as fixed-width words under a valid/ready handshake, least-significant word first.
- Holds the data frozen while streaming, so the core may be restarted as soon as capture has occurred.

Parameters:
- RES_W, 1164, result width in bits (six F3m elements, 2*M bits each, M=97).
- WORD_W, 32, output word width in bits.
- NWORDS, ceil(RES_W/WORD_W) = 37, words per result. Derived; not overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- core_done  input  1  level done flag from the pairing core; stays high until the core is restarted.
- core_out  input  RES_W  pairing result; valid whenever core_done=1.
- flush  input  1  synchronous abort; returns the block to IDLE.
- tx_ready  input  1  host accepts a word this cycle.
- tx_data  output  WORD_W  current word.
- tx_valid  output  1  tx_data valid.
- tx_last  output  1  current word is word NWORDS-1.
- busy  output  1  high in SEND.
- sent  output  1  one-cycle pulse after the final word handshake.
- overrun  output  1  sticky: a result was dropped.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shift register=0; word counter=0; done_q=0. All outputs 0: tx_data, tx_valid, tx_last, busy, sent, overrun.
- Edge detect: done_q <= core_done every cycle. rise = core_done & ~done_q.
  - A core_done already high on the first edge after reset counts as a rise.
- States: IDLE, SEND.
- IDLE, rise=1:
  - Shift register <= {zero pad, core_out}, padded to NWORDS*WORD_W bits.
  - Counter <= 0; state <= SEND.
  - tx_valid=1 from the cycle after the rise edge (capture latency 1).
- SEND:
  - tx_data = shift register[WORD_W-1:0]; tx_valid=1; busy=1.
  - tx_last = (counter == NWORDS-1).
- Handshake (tx_valid & tx_ready), not last word: shift register >>= WORD_W; counter++.
- tx_valid & ~tx_ready: tx_data, tx_last and counter hold unchanged. Valid is never withdrawn except by flush or reset.
- Handshake on the last word:
  - state <= IDLE; tx_valid=0 next cycle; sent=1 for exactly that next cycle.
  - Any bits above RES_W in the last word are 0. With the defaults, tx_data[31:12]=0 and tx_data[11:0]=core_out[1163:1152].
- Rise while in SEND:
  - Normally the result is dropped, overrun <= 1, and the current stream is unaffected.
  - Exception: a rise in the same cycle as the last-word handshake is captured. State stays SEND, the counter returns to 0, and the new word 0 is presented next cycle. No overrun, but sent still pulses.
- flush=1:
  - Next cycle: state=IDLE, tx_valid=0, counter=0, overrun=0, sent=0.
  - The shift register need not be cleared.
  - flush has priority over rise and over the handshake in the same cycle; that rise is discarded, but done_q still updates.
- overrun is cleared only by reset or flush.
- Asynchronous reset mid-stream aborts immediately with all outputs 0. No partial state survives.
- All outputs are registered; no combinational path from tx_ready to tx_valid.
- Throughput: one word per cycle with tx_ready held high. A full result takes NWORDS cycles of SEND (37 by default).

Test Plan:
- Basic stream: core_out = bit i set for i%3==0; raise core_done; tx_ready=1 -> tx_valid rises 1 cycle later; 37 consecutive words; word0=32'h49249249; tx_last only on word 36, whose data = {20'h0, core_out[1163:1152]}; sent pulses once; busy falls with tx_valid.
- Backpressure: same stimulus, tx_ready toggled 1,0,0,1,... randomly -> tx_data/tx_last stable whenever valid&~ready; reassembled 1164 bits equal core_out; exactly 37 handshakes.
- Overrun: during word 10, drop and re-raise core_done with a different core_out -> overrun=1 and stays 1; stream continues with the original data; after sent, block returns to IDLE with no second stream.
- Back-to-back: re-raise core_done with result B exactly on the last-word handshake cycle of result A -> no idle gap; B word0 appears on the next cycle; overrun stays 0; sent pulses once.
- Flush: assert flush at word 5 together with a rising core_done -> next cycle tx_valid=0, busy=0, overrun=0; a later fresh rise streams from word 0.
- Async reset: drive reset low mid-cycle at word 20 -> all outputs 0 immediately, without waiting for a clk edge; after release with core_done held high, the first edge captures and streams the full result.
